bt656_tx: RTL and testbench

- Transmit side of the embedded-sync video link: BT.656-style 10-bit 4:2:2 YCbCr word stream out, with EAV/SAV timing codes, driving the DAC/encoder.
- Contains its own line/field timing generator and pulls 24-bit RGB pixels from upstream (frame buffer reader) with a fixed-latency request.
- Converts RGB to BT.601 studio-range 10-bit YCbCr and decimates chroma to 4:2:2 (co-sited, even pixels).
- Inverse of the receive path, which parses FF/00/00/XY codes and converts YCbCr back to RGB.

---
 rtl/bt656_tx.sv | 190 +++++++++++++++++++
 tb/tb_bt656_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt656_tx.sv
// BT.656 transmitter: a line/field timing generator requests RGB pixels, converts them to
// 10-bit studio-range 4:2:2 YCbCr and emits the embedded-sync word stream with EAV/SAV codes.
module bt656_tx #(
  parameter int H_TOTAL  = 858,
  parameter int H_ACTIVE = 720,
  parameter int V_TOTAL  = 525,
  parameter int F1_START = 263,
  parameter int V_BLANK  = 20
) (
  input  logic        daclk,
  input  logic        rstn,
  input  logic        en,
  output logic        pxreq,
  output logic        pxfirst,
  input  logic [23:0] pxdat,
  output logic [9:0]  dout,
  output logic        dfield
);

  localparam int L     = 2 * H_TOTAL;
  localparam int AS    = L - 2 * H_ACTIVE;
  localparam int WW    = $clog2(L);
  localparam int LW    = $clog2(V_TOTAL);
  localparam int ACC_W = 28;

  localparam logic [WW-1:0] W_LAST    = WW'(L - 1);
  localparam logic [WW-1:0] W_EAV_END = WW'(4);
  localparam logic [WW-1:0] W_SAV     = WW'(AS - 4);
  localparam logic [WW-1:0] W_ACT     = WW'(AS);
  localparam logic [LW-1:0] L_LAST    = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0] L_VB      = LW'(V_BLANK);
  localparam logic [LW-1:0] L_F1      = LW'(F1_START);
  localparam logic [LW-1:0] L_F1V     = LW'(F1_START + V_BLANK);

  localparam logic signed [ACC_W-1:0] KYR = 67315,  KYG = 132155, KYB = 25665;
  localparam logic signed [ACC_W-1:0] KUR = -38856, KUG = -76280, KUB = 115138;
  localparam logic signed [ACC_W-1:0] KVR = 115138, KVG = -96413, KVB = -18724;
  localparam logic signed [ACC_W-1:0] RND   = 32768;
  localparam logic signed [ACC_W-1:0] OFS_Y = 64;
  localparam logic signed [ACC_W-1:0] OFS_C = 512;
  localparam logic signed [ACC_W-1:0] LO    = 4;
  localparam logic signed [ACC_W-1:0] HI    = 1019;

  typedef enum logic [1:0] {SEL_CONST, SEL_CB, SEL_CR, SEL_Y} sel_t;

  // One word slot travelling down the pipeline; word is used only for SEL_CONST.
  typedef struct packed {
    logic [9:0] word;
    sel_t       sel;
    logic       req;
    logic       first;
    logic       even;
    logic       sol;
    logic       f;
  } tok_t;

  function automatic logic signed [ACC_W-1:0] ext8(input logic [7:0] c);
    return $signed({{(ACC_W-8){1'b0}}, c});
  endfunction

  function automatic logic signed [ACC_W-1:0] rnd16(input logic signed [ACC_W-1:0] acc);
    return (acc + RND) >>> 16;
  endfunction

  function automatic logic [9:0] sat10(input logic signed [ACC_W-1:0] v);
    if (v < LO)      return LO[9:0];
    else if (v > HI) return HI[9:0];
    else             return v[9:0];
  endfunction

  logic [WW-1:0] wcnt, aofs, sofs;
  logic [LW-1:0] lcnt;
  logic          fbit, vbit, hbit;
  logic [1:0]    cidx;
  logic [9:0]    xy_c;
  tok_t          tok_c;

  always_ff @(posedge daclk or negedge rstn) begin
    if (!rstn) begin
      wcnt <= '0;
      lcnt <= '0;
    end else if (!en) begin
      wcnt <= '0;
      lcnt <= '0;
    end else if (wcnt == W_LAST) begin
      wcnt <= '0;
      lcnt <= (lcnt == L_LAST) ? '0 : lcnt + 1'b1;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    fbit  = (lcnt >= L_F1);
    vbit  = (lcnt < L_VB) || (fbit && (lcnt < L_F1V));
    hbit  = (wcnt < W_EAV_END);
    aofs  = wcnt - W_ACT;
    sofs  = wcnt - W_SAV;
    xy_c  = {1'b1, fbit, vbit, hbit, vbit ^ hbit, fbit ^ hbit, fbit ^ vbit,
             fbit ^ vbit ^ hbit, 2'b00};
    cidx  = hbit ? wcnt[1:0] : sofs[1:0];
    tok_c = '0;
    tok_c.sol  = (wcnt == '0);
    tok_c.f    = fbit;
    tok_c.word = wcnt[0] ? 10'h040 : 10'h200;
    if (hbit || ((wcnt >= W_SAV) && (wcnt < W_ACT))) begin
      case (cidx)
        2'd0:    tok_c.word = 10'h3FF;
        2'd3:    tok_c.word = xy_c;
        default: tok_c.word = 10'h000;
      endcase
    end else if ((wcnt >= W_ACT) && !vbit) begin
      // Even slots (Cb/Cr) each pull one pixel; Cb slots mark the chroma-carrying pixel.
      tok_c.req   = ~aofs[0];
      tok_c.even  = (aofs[1:0] == 2'b00);
      tok_c.first = (aofs == '0) && (lcnt == L_VB);
      case (aofs[1:0])
        2'd0:    tok_c.sel = SEL_CB;
        2'd2:    tok_c.sel = SEL_CR;
        default: tok_c.sel = SEL_Y;
      endcase
    end
  end

  logic              vld_p0, vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
  tok_t              tok_p0, tok_p1, tok_p2, tok_p3, tok_p4, tok_p5;
  logic [23:0]       rgb_p3;
  logic signed [ACC_W-1:0] prod_p4 [9];
  logic [9:0]        y_p5, cb_p5, cr_p5;

  always_ff @(posedge daclk or negedge rstn) begin
    if (!rstn) begin
      {vld_p0, vld_p1, vld_p2, vld_p3, vld_p4, vld_p5} <= '0;
      pxreq   <= 1'b0;
      pxfirst <= 1'b0;
      dout    <= 10'h200;
      dfield  <= 1'b0;
    end else begin
      vld_p0  <= en;
      vld_p1  <= en & vld_p0;
      vld_p2  <= en & vld_p1;
      vld_p3  <= en & vld_p2;
      vld_p4  <= en & vld_p3;
      vld_p5  <= en & vld_p4;
      // p1: request goes out; pixel arrives during p2 and is captured at p3
      pxreq   <= en & vld_p0 & tok_p0.req;
      pxfirst <= en & vld_p0 & tok_p0.first;
      if (en && vld_p5) begin
        case (tok_p5.sel)
          SEL_CB:  dout <= cb_p5;
          SEL_CR:  dout <= cr_p5;
          SEL_Y:   dout <= y_p5;
          default: dout <= tok_p5.word;
        endcase
        if (tok_p5.sol) dfield <= tok_p5.f;
      end else begin
        dout <= 10'h200;
      end
    end
  end

  always_ff @(posedge daclk) begin
    tok_p0 <= tok_c;
    tok_p1 <= tok_p0;
    tok_p2 <= tok_p1;
    tok_p3 <= tok_p2;
    tok_p4 <= tok_p3;
    tok_p5 <= tok_p4;
    // p3: pixel capture
    rgb_p3 <= pxdat;
    // p4: nine coefficient products
    prod_p4[0] <= KYR * ext8(rgb_p3[23:16]);
    prod_p4[1] <= KYG * ext8(rgb_p3[15:8]);
    prod_p4[2] <= KYB * ext8(rgb_p3[7:0]);
    prod_p4[3] <= KUR * ext8(rgb_p3[23:16]);
    prod_p4[4] <= KUG * ext8(rgb_p3[15:8]);
    prod_p4[5] <= KUB * ext8(rgb_p3[7:0]);
    prod_p4[6] <= KVR * ext8(rgb_p3[23:16]);
    prod_p4[7] <= KVG * ext8(rgb_p3[15:8]);
    prod_p4[8] <= KVB * ext8(rgb_p3[7:0]);
    // p5: round, offset, clamp; chroma held from the even pixel across its odd partner
    if (vld_p4 && tok_p4.req)
      y_p5 <= sat10(OFS_Y + rnd16(prod_p4[0] + prod_p4[1] + prod_p4[2]));
    if (vld_p4 && tok_p4.even) begin
      cb_p5 <= sat10(OFS_C + rnd16(prod_p4[3] + prod_p4[4] + prod_p4[5]));
      cr_p5 <= sat10(OFS_C + rnd16(prod_p4[6] + prod_p4[7] + prod_p4[8]));
    end
  end

endmodule

// File: tb/tb_bt656_tx.sv
// Bench for bt656_tx on a reduced raster: a reference timing/colour model feeds a scoreboard
// of expected words and requests, while a driver answers every pxreq with the model's pixel.
module tb_bt656_tx;

  localparam int H_TOTAL  = 40;
  localparam int H_ACTIVE = 16;
  localparam int V_TOTAL  = 12;
  localparam int F1_START = 6;
  localparam int V_BLANK  = 2;
  localparam int L        = 2 * H_TOTAL;
  localparam int AS       = L - 2 * H_ACTIVE;
  localparam int FRAME    = L * V_TOTAL;

  logic        daclk = 1'b0;
  logic        rstn, en, pxreq, pxfirst, dfield;
  logic [23:0] pxdat;
  logic [9:0]  dout;

  always #5 daclk = ~daclk;

  bt656_tx #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL),
    .F1_START(F1_START), .V_BLANK(V_BLANK)
  ) dut (
    .daclk(daclk), .rstn(rstn), .en(en), .pxreq(pxreq), .pxfirst(pxfirst),
    .pxdat(pxdat), .dout(dout), .dfield(dfield)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {int due; int word; bit sol; bit f; bit act;} ent_t;
  typedef struct {int due; bit first;} req_t;
  ent_t        dq[$];
  req_t        rq[$];
  logic [23:0] pq[$];

  int          cyc = 0;
  int          ml = 0, mw = 0, mode = 0, exp_df = 0;
  bit          mon = 0;
  logic [23:0] pe, po;
  int          n_req, n_first, n_3ff;
  int          h1 = 0, h2 = 0, h3 = 0;
  logic [7:0]  seen_mask = '0;
  bit          pair_seen = 0, white_seen = 0;

  function automatic int xyw(input int f, input int v, input int h);
    return 512 | (f << 8) | (v << 7) | (h << 6) | ((v ^ h) << 5) | ((f ^ h) << 4) |
           ((f ^ v) << 3) | ((f ^ v ^ h) << 2);
  endfunction

  function automatic int cv(input int kr, input int kg, input int kb, input int off,
                            input logic [23:0] p);
    int s;
    s = kr * int'(p[23:16]) + kg * int'(p[15:8]) + kb * int'(p[7:0]) + 32768;
    s = off + (s >>> 16);
    if (s < 4) s = 4;
    if (s > 1019) s = 1019;
    return s;
  endfunction

  function automatic int ym(input logic [23:0] p);  return cv(67315, 132155, 25665, 64, p);    endfunction
  function automatic int cbm(input logic [23:0] p); return cv(-38856, -76280, 115138, 512, p); endfunction
  function automatic int crm(input logic [23:0] p); return cv(115138, -96413, -18724, 512, p); endfunction

  function automatic logic [23:0] gen(input int n);
    case (mode)
      0:       return 24'hFFFFFF;
      1:       return 24'h000000;
      2:       return (n % 2 == 0) ? 24'hFF0000 : 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic int code(input int i, input int xy);
    case (i)
      0:       return 'h3FF;
      3:       return xy;
      default: return 0;
    endcase
  endfunction

  task automatic push_px(input logic [23:0] p, input bit first);
    req_t r;
    r.due = cyc + 1;
    r.first = first;
    pq.push_back(p);
    rq.push_back(r);
  endtask

  task automatic step();
    int f, v, a;
    ent_t e;
    f = (ml >= F1_START) ? 1 : 0;
    v = ((ml < V_BLANK) || (ml >= F1_START && ml < F1_START + V_BLANK)) ? 1 : 0;
    e.due = cyc + 6;
    e.sol = (mw == 0);
    e.f = f[0];
    e.act = 0;
    e.word = (mw % 2 == 1) ? 'h040 : 'h200;
    if (mw < 4) e.word = code(mw, xyw(f, v, 1));
    else if (mw >= AS - 4 && mw < AS) e.word = code(mw - (AS - 4), xyw(f, v, 0));
    else if (mw >= AS && v == 0) begin
      a = mw - AS;
      e.act = 1;
      case (a % 4)
        0: begin pe = gen(a / 2); push_px(pe, (a == 0 && ml == V_BLANK)); e.word = cbm(pe); end
        1: e.word = ym(pe);
        2: begin po = gen(a / 2); push_px(po, 1'b0); e.word = crm(pe); end
        default: e.word = ym(po);
      endcase
    end
    dq.push_back(e);
    if (mw == L - 1) begin
      mw = 0;
      ml = (ml == V_TOTAL - 1) ? 0 : ml + 1;
    end else mw++;
  endtask

  // Reference model: advances on every sampled edge, flushes on reset or en low.
  initial forever begin
    @(posedge daclk or negedge rstn);
    if (!rstn) begin
      ml = 0; mw = 0; exp_df = 0;
      dq.delete(); rq.delete(); pq.delete();
    end else begin
      cyc++;
      if (!en) begin
        ml = 0; mw = 0;
        dq.delete(); rq.delete(); pq.delete();
      end else step();
    end
  end

  // Output checker, sampling on the falling edge.
  initial forever begin
    int ed, er, ef;
    bit act;
    ent_t e;
    req_t r;
    @(negedge daclk);
    if (mon) begin
      ed = 'h200; er = 0; ef = 0; act = 0;
      if (dq.size() > 0 && dq[0].due == cyc) begin
        e = dq.pop_front();
        ed = e.word;
        act = e.act;
        if (e.sol) exp_df = int'(e.f);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        er = 1;
        ef = int'(r.first);
      end
      chk("dout", int'(dout), ed);
      chk("pxreq", int'(pxreq), er);
      chk("pxfirst", int'(pxfirst), ef);
      chk("dfield", int'(dfield), exp_df);
      if (act) chk("active_range", int'(dout >= 10'd4 && dout <= 10'd1019), 1);
      if (h3 == 'h3FF && h2 == 0 && h1 == 0) begin
        chk("xy_prot", int'(dout), xyw(int'(dout[8]), int'(dout[7]), int'(dout[6])));
        seen_mask[dout[8:6]] = 1'b1;
      end
      if (h3 == 'h169 && h2 == 'h146 && h1 == 'h3C0 && dout == 10'h040) pair_seen = 1;
      if (h3 == 'h200 && h2 == 'h3AC && h1 == 'h200 && dout == 10'h3AC) white_seen = 1;
      h3 = h2; h2 = h1; h1 = int'(dout);
      if (pxreq) n_req++;
      if (pxfirst) n_first++;
      if (dout == 10'h3FF) n_3ff++;
    end
  end

  // Pixel source: answer each request with the model's pixel in the following cycle.
  initial forever begin
    logic [23:0] nv;
    @(negedge daclk);
    if (pxreq === 1'b1) begin
      nv = 24'h0;
      if (pq.size() == 0) chk("pixel_queue_nonempty", 0, 1);
      else nv = pq.pop_front();
      @(posedge daclk);
      #1 pxdat = nv;
    end
  end

  task automatic measure_lat(input string tag);
    int k;
    k = 0;
    do begin
      @(posedge daclk);
      k++;
      #1;
    end while (dout != 10'h3FF && k < 20);
    chk(tag, k, 7);
  endtask

  initial begin
    int k;
    rstn = 1'b1; en = 1'b0; pxdat = '0;
    #3 rstn = 1'b0;
    #1;
    chk("reset_dout", int'(dout), 'h200);
    chk("reset_pxreq", int'(pxreq), 0);
    chk("reset_pxfirst", int'(pxfirst), 0);
    chk("reset_dfield", int'(dfield), 0);
    repeat (3) @(posedge daclk);
    #2 rstn = 1'b1; mon = 1;
    @(posedge daclk);
    #2 en = 1'b1;
    measure_lat("start_latency");

    n_req = 0; n_first = 0; n_3ff = 0;
    repeat (FRAME) @(negedge daclk);
    #1;
    chk("frame_pxreq_count", n_req, (V_TOTAL - 2 * V_BLANK) * H_ACTIVE);
    chk("frame_pxfirst_count", n_first, 1);
    chk("frame_3ff_count", n_3ff, 2 * V_TOTAL);

    mode = 1; repeat (FRAME) @(posedge daclk);
    mode = 2; repeat (FRAME) @(posedge daclk);
    mode = 3; repeat (FRAME) @(posedge daclk);

    k = 0;
    while (pxreq !== 1'b1 && k < 2 * FRAME) begin
      @(posedge daclk); #1; k++;
    end
    chk("active_line_reached", int'(pxreq === 1'b1), 1);
    @(posedge daclk);
    #2 en = 1'b0;
    @(posedge daclk);
    #1;
    chk("drop_dout", int'(dout), 'h200);
    chk("drop_pxreq", int'(pxreq), 0);
    repeat (5) @(posedge daclk);
    #2 en = 1'b1;
    measure_lat("reenable_latency");

    repeat (8 * L + 17) @(posedge daclk);
    #1 chk("field1_before_reset", int'(dfield), 1);
    #1 rstn = 1'b0;
    #1;
    chk("midline_reset_dout", int'(dout), 'h200);
    chk("midline_reset_pxreq", int'(pxreq), 0);
    chk("midline_reset_dfield", int'(dfield), 0);
    repeat (3) @(posedge daclk);
    #2 rstn = 1'b1;
    measure_lat("post_reset_latency");
    repeat (3 * L) @(posedge daclk);

    chk("xy_combos_seen", int'(seen_mask), 'hFF);
    chk("pair_sequence_seen", int'(pair_seen), 1);
    chk("white_sequence_seen", int'(white_seen), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
